// File: rtl/ex_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_wb_pipe
//  Brief    : EX/MEM and MEM/WB pipeline registers, forwarding sources and
//             MEM-stage data-cache req/ack sequencing with pipeline stall.
//             Optional stall-cycle counter enabled by EX_MEM_WB_STALL_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memtoreg_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [DATA_W-1:0] ex_alu_i,
  input  logic [DATA_W-1:0] ex_rs2data_i,
  input  logic [4:0]        ex_rdaddr_i,
  output logic              mem_regwrite_o,
  output logic [4:0]        mem_rdaddr_o,
  output logic [DATA_W-1:0] mem_alu_o,
  output logic              wb_regwrite_o,
  output logic [4:0]        wb_rdaddr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              dc_req_o,
  output logic              dc_we_o,
  output logic [DATA_W-1:0] dc_addr_o,
  output logic [DATA_W-1:0] dc_wdata_o,
  input  logic              dc_ack_i,
  input  logic [DATA_W-1:0] dc_rdata_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_ACCESS = 1'b1;

  // EX/MEM register
  logic              mem_valid_q;
  logic              mem_regwrite_q;
  logic              mem_memtoreg_q;
  logic              mem_memread_q;
  logic              mem_memwrite_q;
  logic [DATA_W-1:0] mem_alu_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [4:0]        mem_rdaddr_q;

  // MEM/WB register
  logic              wb_regwrite_q;
  logic [4:0]        wb_rdaddr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              w_mem_op;
  logic              w_stall;
  logic [DATA_W-1:0] w_wb_data_d;

  // A memory op exists only for a real (non-bubble) instruction in MEM.
  assign w_mem_op = mem_valid_q & (mem_memread_q | mem_memwrite_q);
  // Stall until the cache acks; a same-cycle ack costs no extra cycles.
  assign w_stall  = w_mem_op & ~dc_ack_i;
  assign w_wb_data_d = mem_memtoreg_q ? dc_rdata_i : mem_alu_q;

  // EX/MEM capture: load on advance, hold while stalled, bubble clears flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_alu_q      <= '0;
      mem_wdata_q    <= '0;
      mem_rdaddr_q   <= '0;
    end else if (!w_stall) begin
      mem_valid_q    <= ex_valid_i;
      mem_regwrite_q <= ex_valid_i & ex_regwrite_i;
      mem_memtoreg_q <= ex_valid_i & ex_memtoreg_i;
      mem_memread_q  <= ex_valid_i & ex_memread_i;
      mem_memwrite_q <= ex_valid_i & ex_memwrite_i;
      mem_alu_q      <= ex_alu_i;
      mem_wdata_q    <= ex_rs2data_i;
      mem_rdaddr_q   <= ex_rdaddr_i;
    end
  end

  // Access sequencer next state: wait in ACCESS until the cache acks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:   if (w_mem_op && !dc_ack_i) state_d = c_ACCESS;
      c_ACCESS: if (dc_ack_i || !w_mem_op) state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  // Access sequencer state register; reset abandons any outstanding access.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  // MEM/WB capture: load data is sampled in the ack cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_regwrite_q <= 1'b0;
      wb_rdaddr_q   <= '0;
      wb_data_q     <= '0;
    end else if (!w_stall) begin
      wb_regwrite_q <= mem_valid_q & mem_regwrite_q;
      wb_rdaddr_q   <= mem_rdaddr_q;
      wb_data_q     <= w_wb_data_d;
    end
  end

  // Request stays asserted (with stable address/data) for the whole access.
  assign dc_req_o       = w_mem_op & ((state_q == c_IDLE) | (state_q == c_ACCESS));
  assign dc_we_o        = w_mem_op & mem_memwrite_q;
  assign dc_addr_o      = mem_alu_q;
  assign dc_wdata_o     = mem_wdata_q;
  assign stall_o        = w_stall;

  assign mem_regwrite_o = mem_valid_q & mem_regwrite_q;
  assign mem_rdaddr_o   = mem_rdaddr_q;
  assign mem_alu_o      = mem_alu_q;
  assign wb_regwrite_o  = wb_regwrite_q;
  assign wb_rdaddr_o    = wb_rdaddr_q;
  assign wb_data_o      = wb_data_q;

`ifdef EX_MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (w_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage core.
- Sources the Mem_RegWrite/Mem_RDaddr and WB_RegWrite/WB_RDaddr signals consumed by the forwarding unit, plus the matching forwarded data.
- Sequences the MEM-stage data-cache access with a req/ack handshake.
- Freezes the pipeline via stall_o until the cache acknowledges.

Parameters:
DATA_W, 32, data/address width
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-high reset
ex_valid_i  input  1  EX stage holds a real instruction (0 = bubble)
ex_regwrite_i  input  1  instruction writes rd
ex_memtoreg_i  input  1  writeback data comes from memory
ex_memread_i  input  1  load
ex_memwrite_i  input  1  store
ex_alu_i  input  DATA_W  ALU result / memory address
ex_rs2data_i  input  DATA_W  store data (post-forwarding)
ex_rdaddr_i  input  5  destination register
mem_regwrite_o  output  1  MEM-stage RegWrite (to forwarding)
mem_rdaddr_o  output  5  MEM-stage rd (to forwarding)
mem_alu_o  output  DATA_W  MEM-stage ALU result (forward path)
wb_regwrite_o  output  1  WB-stage RegWrite (to forwarding and regfile)
wb_rdaddr_o  output  5  WB-stage rd
wb_data_o  output  DATA_W  selected writeback data
dc_req_o  output  1  data-cache request
dc_we_o  output  1  1 = write
dc_addr_o  output  DATA_W  cache address
dc_wdata_o  output  DATA_W  store data
dc_ack_i  input  1  cache done; dc_rdata_i valid this cycle
dc_rdata_i  input  DATA_W  load data
stall_o  output  1  freeze PC, IF/ID, ID/EX and this block
stall_cycles_o  output  CNT_W  stall-cycle count (optional feature)

Behaviour:
- Reset: all valid/regwrite/memread/memwrite flags = 0; rd addresses = 0; data = 0; FSM = IDLE; counter = 0.
- Reset outputs: mem_regwrite_o = 0, wb_regwrite_o = 0, dc_req_o = 0, stall_o = 0.
- EX/MEM register: captures the ex_* inputs each edge when stall_o = 0; holds when stall_o = 1.
- Bubble handling: ex_valid_i = 0 loads a bubble (all control flags 0).
- mem_regwrite_o is the registered flag qualified by MEM valid.
- Memory op = MEM valid & (memread | memwrite).
- FSM IDLE:
  - Memory op present → dc_req_o = 1 combinationally in the same cycle.
  - dc_ack_i = 0 → stall_o = 1, go to ACCESS.
  - dc_ack_i = 1 → no stall, advance.
- FSM ACCESS:
  - dc_req_o held at 1; dc_we_o, dc_addr_o and dc_wdata_o stable from the EX/MEM register.
  - stall_o = 1 until dc_ack_i.
  - On ack: stall_o = 0, go to IDLE, instruction advances that edge.
- Stall equation: stall_o = memory op & ~dc_ack_i. Latency is 0 extra cycles on a same-cycle ack, and N stall cycles for an ack N cycles after the request.
- dc_ack_i with no request outstanding is ignored.
- MEM/WB register:
  - stall_o = 0: loads regwrite, rdaddr, and data. Data = dc_rdata_i (sampled in the ack cycle) if memtoreg, else the ALU result.
  - stall_o = 1: holds. A repeated regfile write of the same value is harmless.
- Store: wb_regwrite_o follows the instruction's regwrite (0 for stores).
- Back-to-back memory ops: the FSM returns to IDLE on ack. The next op enters MEM the same edge and requests in the following cycle.
- rd = 0: passed through unchanged; the forwarding unit masks it.
- Reset mid-access: the state is abandoned. dc_req_o drops in the cycle after reset is sampled, and a late ack is ignored.

Optional Feature:
- Macro: EX_MEM_WB_STALL_CNT_EN.
- Defined:
  - stall_cycles_o increments by 1 every cycle stall_o = 1.
  - Saturates at all-ones.
  - Cleared by rst_i.
- Undefined: stall_cycles_o is tied to 0 and no counter logic is present.

Test Plan:
- ALU op (regwrite = 1, rd = 5, alu = 0x10) with ex_valid = 1 → next cycle mem_regwrite_o = 1, mem_rdaddr_o = 5; following cycle wb_rdaddr_o = 5, wb_data_o = 0x10; stall_o stays 0.
- Load (rd = 7, addr = 0x40), ack 3 cycles after the request with rdata = 0xDEADBEEF → stall_o high exactly 3 cycles; dc_addr_o = 0x40 throughout; then wb_data_o = 0xDEADBEEF and wb_rdaddr_o = 7; counter = 3 (macro on) or 0 (macro off).
- Store (addr = 0x80, rs2 = 0x1234) with same-cycle ack → dc_we_o = 1, dc_wdata_o = 0x1234; stall_o = 0; next cycle wb_regwrite_o = 0.
- Two back-to-back loads, each acked after 1 cycle → each stalls 1 cycle; wb outputs show both loads in order with the correct data.
- Assert rst_i during ACCESS, then pulse ack the cycle after → all outputs 0 the cycle after reset; the stray ack is ignored and stall_o = 0.
- Bubble (ex_valid = 0) with regwrite = 1 and memread = 1 → mem_regwrite_o = 0; no dc_req_o; no stall.
